// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and small helpers for the 2x1 arbiter slice.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // SEQ is folded into NONSEQ; IDLE and BUSY carry no transfer.
    function automatic logic is_transfer(input logic [1:0] htrans);
        logic result_s;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: result_s = 1'b1;
            default:                   result_s = 1'b0;
        endcase
        return result_s;
    endfunction

endpackage

// File: rtl/ahb_lite_hold_stage.sv
// One-deep holding register for a master's address-phase signals plus its
// pending flag; a capture stores the live address, a clear retires it.
module ahb_lite_hold_stage
    import ahb_lite_pkg::*;
#(
    parameter int HADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   capture,
    input  logic                   clear,
    input  logic [HADDR_WIDTH-1:0] haddr,
    input  logic [2:0]             hsize,
    input  logic                   hwrite,
    output logic                   pending,
    output logic [HADDR_WIDTH-1:0] hold_haddr,
    output logic [2:0]             hold_hsize,
    output logic                   hold_hwrite
);

    logic                   pending_r;
    logic [HADDR_WIDTH-1:0] haddr_r;
    logic [2:0]             hsize_r;
    logic                   hwrite_r;

    // Pending flag and held address-phase fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 1'b0;
            haddr_r   <= {HADDR_WIDTH{1'b0}};
            hsize_r   <= 3'b000;
            hwrite_r  <= 1'b0;
        end else if (capture) begin
            pending_r <= 1'b1;
            haddr_r   <= haddr;
            hsize_r   <= hsize;
            hwrite_r  <= hwrite;
        end else if (clear) begin
            pending_r <= 1'b0;
        end
    end

    assign pending     = pending_r;
    assign hold_haddr  = haddr_r;
    assign hold_hsize  = hsize_r;
    assign hold_hwrite = hwrite_r;

endmodule

// File: rtl/ahb_lite_arbiter_2x1.sv
// Two-master AHB-Lite arbiter: round-robin address-phase grant with one-deep
// per-master holding, wait-state lock and data-phase owner tracking.
module ahb_lite_arbiter_2x1
    import ahb_lite_pkg::*;
#(
    parameter int HADDR_WIDTH = 32,
    parameter int HDATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0][HADDR_WIDTH-1:0] m_HADDR,
    input  logic [1:0][1:0]             m_HTRANS,
    input  logic [1:0][2:0]             m_HSIZE,
    input  logic [1:0]                  m_HWRITE,
    input  logic [1:0][HDATA_WIDTH-1:0] m_HWDATA,
    output logic [1:0][HDATA_WIDTH-1:0] m_HRDATA,
    output logic [1:0]                  m_HREADY,
    output logic [1:0]                  m_HRESP,
    output logic [HADDR_WIDTH-1:0]      s_HADDR,
    output logic [1:0]                  s_HTRANS,
    output logic [2:0]                  s_HSIZE,
    output logic                        s_HWRITE,
    output logic [HDATA_WIDTH-1:0]      s_HWDATA,
    input  logic [HDATA_WIDTH-1:0]      s_HRDATA,
    input  logic                        s_HREADY,
    input  logic                        s_HRESP,
    output logic                        s_HMASTER
);

    logic [1:0]                  pending_s;
    logic [1:0][HADDR_WIDTH-1:0] hold_haddr_s;
    logic [1:0][2:0]             hold_hsize_s;
    logic [1:0]                  hold_hwrite_s;
    logic [1:0]                  cand_s;
    logic [1:0]                  req_s;
    logic [1:0]                  capture_s;
    logic [1:0]                  clear_s;
    logic                        grant_s;
    logic                        accept_s;
    logic                        last_grant_r;
    logic                        d_valid_r;
    logic                        d_owner_r;
    logic                        lock_r;
    logic                        lock_grant_r;

    for (genvar gi = 0; gi < 2; gi++) begin : g_hold
        ahb_lite_hold_stage #(
            .HADDR_WIDTH(HADDR_WIDTH)
        ) u_hold (
            .clk        (clk),
            .reset      (reset),
            .capture    (capture_s[gi]),
            .clear      (clear_s[gi]),
            .haddr      (m_HADDR[gi]),
            .hsize      (m_HSIZE[gi]),
            .hwrite     (m_HWRITE[gi]),
            .pending    (pending_s[gi]),
            .hold_haddr (hold_haddr_s[gi]),
            .hold_hsize (hold_hsize_s[gi]),
            .hold_hwrite(hold_hwrite_s[gi])
        );
    end

    // Candidates use pending state and live HTRANS only, so the address path
    // never depends on s_HREADY.
    always_comb begin
        cand_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cand_s[i] = pending_s[i] | is_transfer(m_HTRANS[i]);
        end
    end

    // Round-robin grant, frozen while a NONSEQ is stalled by the slave.
    always_comb begin
        grant_s = 1'b0;
        if (lock_r) begin
            grant_s = lock_grant_r;
        end else begin
            case (cand_s)
                2'b01:   grant_s = 1'b0;
                2'b10:   grant_s = 1'b1;
                2'b11:   grant_s = ~last_grant_r;
                default: grant_s = 1'b0;
            endcase
        end
    end

    // Shared address phase from the granted master's held or live signals.
    always_comb begin
        s_HTRANS = HTRANS_IDLE;
        if (lock_r || (cand_s != 2'b00)) begin
            s_HTRANS = HTRANS_NONSEQ;
        end else begin
            s_HTRANS = HTRANS_IDLE;
        end
        if (pending_s[grant_s]) begin
            s_HADDR  = hold_haddr_s[grant_s];
            s_HSIZE  = hold_hsize_s[grant_s];
            s_HWRITE = hold_hwrite_s[grant_s];
        end else begin
            s_HADDR  = m_HADDR[grant_s];
            s_HSIZE  = m_HSIZE[grant_s];
            s_HWRITE = m_HWRITE[grant_s];
        end
    end

    assign accept_s = (s_HTRANS == HTRANS_NONSEQ) & s_HREADY;

    // Per-master response: the data-phase owner sees the slave, others see pending.
    always_comb begin
        m_HREADY = 2'b00;
        m_HRESP  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (d_valid_r && (d_owner_r == 1'(i))) begin
                m_HREADY[i] = s_HREADY;
                m_HRESP[i]  = s_HRESP;
            end else begin
                m_HREADY[i] = ~pending_s[i];
                m_HRESP[i]  = HRESP_OKAY;
            end
        end
    end

    // A real request (master sees HREADY high) that does not issue now is held.
    always_comb begin
        req_s     = 2'b00;
        clear_s   = 2'b00;
        capture_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_s[i]     = is_transfer(m_HTRANS[i]) & m_HREADY[i];
            clear_s[i]   = accept_s & (grant_s == 1'(i));
            capture_s[i] = req_s[i] & ~clear_s[i];
        end
    end

    // Arbitration history, wait-state lock and data-phase ownership.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= 1'b1;
            d_valid_r    <= 1'b0;
            d_owner_r    <= 1'b0;
            lock_r       <= 1'b0;
            lock_grant_r <= 1'b0;
        end else begin
            if (accept_s) begin
                last_grant_r <= grant_s;
                d_valid_r    <= 1'b1;
                d_owner_r    <= grant_s;
            end else if (s_HREADY) begin
                d_valid_r    <= 1'b0;
            end
            if ((s_HTRANS == HTRANS_NONSEQ) && !s_HREADY) begin
                lock_r       <= 1'b1;
                lock_grant_r <= grant_s;
            end else begin
                lock_r       <= 1'b0;
            end
        end
    end

    assign m_HRDATA  = {s_HRDATA, s_HRDATA};
    assign s_HWDATA  = m_HWDATA[d_owner_r];
    assign s_HMASTER = d_owner_r;

endmodule
